// File: rtl/square_pkg.sv
// Shared constants and helpers for the rotating-square display.
// Contents: position width/count, active-low segment patterns for the upper and
// lower squares, blank patterns, and a one-step position helper.
package square_pkg;

    localparam int unsigned POS_W   = 3;
    localparam int unsigned NUM_POS = 8;

    // Active-low {dp,g,f,e,d,c,b,a}
    localparam logic [7:0] SSEG_UPPER = 8'b1001_1100;  // a,b,f,g lit
    localparam logic [7:0] SSEG_LOWER = 8'b1010_0011;  // c,d,e,g lit
    localparam logic [7:0] SSEG_BLANK = 8'hFF;

    localparam logic [3:0] AN_OFF = 4'b1111;

    // One position step; the 3-bit width gives the mod-8 wrap for free.
    function automatic logic [POS_W-1:0] pos_step(input logic [POS_W-1:0] pos,
                                                  input logic             cw);
        logic [POS_W-1:0] cw_next;
        logic [POS_W-1:0] ccw_next;
        cw_next  = pos + POS_W'(1);
        ccw_next = pos - POS_W'(1);
        return cw ? cw_next : ccw_next;
    endfunction

endpackage

// File: rtl/square_pos_decoder.sv
// Combinational decode of the square position onto the 4-digit display.
// Ports:
//   pos_i  [2:0]  registered square position 0..7
//   an_o   [3:0]  digit anodes, active-low, an_o[3] = leftmost
//   sseg_o [7:0]  segments, active-low, {dp,g,f,e,d,c,b,a}
// Positions 0..3 show the upper square on digits 3..0; positions 4..7 show the
// lower square on digits 0..3, so the square travels a closed loop.
module square_pos_decoder
    import square_pkg::*;
(
    input  logic [POS_W-1:0] pos_i,
    output logic [3:0]       an_o,
    output logic [7:0]       sseg_o
);

    always_comb begin
        an_o   = AN_OFF;
        sseg_o = SSEG_BLANK;
        if (!pos_i[2]) begin
            sseg_o                    = SSEG_UPPER;
            an_o[2'd3 - pos_i[1:0]]   = 1'b0;
        end else begin
            sseg_o                    = SSEG_LOWER;
            an_o[pos_i[1:0]]          = 1'b0;
        end
    end

endmodule

// File: rtl/square_rotation_ctrl.sv
// Rotating-square sequencer: divides clk into step ticks and steps a 3-bit
// position clockwise or counter-clockwise, driving the display directly.
// Ports:
//   clk        system clock, rising edge
//   reset_n    synchronous reset, active-low
//   en         1 = rotate, 0 = freeze prescaler and position
//   cw         requested direction (1 = clockwise), sampled only at a step
//   step_tick  one-cycle pulse, high in the cycle the new position appears
//   pos [2:0]  current square position
//   dir        effective direction latched at the last step (1 = cw)
//   an  [3:0]  digit anodes, active-low
//   sseg[7:0]  segments, active-low, {dp,g,f,e,d,c,b,a}
// Optional build macro AUTO_REVERSE_EN: each wrapping step toggles a reverse
// bit that is XORed into the sampled direction.
module square_rotation_ctrl
    import square_pkg::*;
#(
    parameter int unsigned TICK_DIV = 25_000_000
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic             cw,
    output logic             step_tick,
    output logic [POS_W-1:0] pos,
    output logic             dir,
    output logic [3:0]       an,
    output logic [7:0]       sseg
);

    localparam int unsigned      CNT_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [POS_W-1:0] pos_q, pos_d;
    logic             dir_q, dir_d;
    logic             tick_q, tick_d;
    logic             step;
    logic             eff_cw;

    assign step = en && (cnt_q == CNT_MAX);

`ifdef AUTO_REVERSE_EN
    logic rev_q, rev_d;
    logic wraps;

    assign eff_cw = cw ^ rev_q;
    assign wraps  = eff_cw ? (pos_q == POS_W'(NUM_POS - 1)) : (pos_q == '0);

    always_comb begin
        rev_d = rev_q;
        if (step && wraps) begin
            rev_d = ~rev_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rev_q <= 1'b0;
        end else begin
            rev_q <= rev_d;
        end
    end
`else
    assign eff_cw = cw;
`endif

    always_comb begin
        cnt_d  = cnt_q;
        pos_d  = pos_q;
        dir_d  = dir_q;
        tick_d = step;
        if (en) begin
            if (step) begin
                cnt_d = '0;
                // Direction and position update on the same edge, so a new
                // direction applies to the very step that samples it.
                dir_d = eff_cw;
                pos_d = pos_step(pos_q, eff_cw);
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt_q  <= '0;
            pos_q  <= '0;
            dir_q  <= 1'b1;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            pos_q  <= pos_d;
            dir_q  <= dir_d;
            tick_q <= tick_d;
        end
    end

    assign step_tick = tick_q;
    assign pos       = pos_q;
    assign dir       = dir_q;

    square_pos_decoder u_decoder (
        .pos_i  (pos_q),
        .an_o   (an),
        .sseg_o (sseg)
    );

endmodule

// File: tb/tb_square_rotation_ctrl.sv
// Randomized self-checking bench for square_rotation_ctrl (TICK_DIV = 4).
module tb_square_rotation_ctrl;

    localparam int DIV = 4;

    logic       clk;
    logic       reset_n;
    logic       en;
    logic       cw;
    logic       step_tick;
    logic [2:0] pos;
    logic       dir;
    logic [3:0] an;
    logic [7:0] sseg;

    int n_vec;
    int n_err;

    // Reference model state
    int m_cnt;
    int m_pos;
    int m_dir;
    int m_tick;

    square_rotation_ctrl #(
        .TICK_DIV (DIV)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .en        (en),
        .cw        (cw),
        .step_tick (step_tick),
        .pos       (pos),
        .dir       (dir),
        .an        (an),
        .sseg      (sseg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Model of one clock edge, written from the behavioural rules.
    task automatic model_edge(input logic r_n, input logic e, input logic c);
        if (!r_n) begin
            m_cnt  = 0;
            m_pos  = 0;
            m_dir  = 1;
            m_tick = 0;
        end else begin
            m_tick = (e && m_cnt == DIV - 1) ? 1 : 0;
            if (e) begin
                if (m_cnt == DIV - 1) begin
                    m_cnt = 0;
                    m_dir = c ? 1 : 0;
                    m_pos = c ? (m_pos + 1) % 8 : (m_pos + 7) % 8;
                end else begin
                    m_cnt = m_cnt + 1;
                end
            end
        end
    endtask

    task automatic check_all();
        int         digit;
        logic [3:0] exp_an;
        logic [7:0] exp_sseg;
        digit    = (m_pos < 4) ? 3 - m_pos : m_pos - 4;
        exp_an   = 4'hF & ~(4'b0001 << digit);
        exp_sseg = (m_pos < 4) ? 8'b1001_1100 : 8'b1010_0011;
        check_eq("step_tick", 32'(step_tick), 32'(m_tick));
        check_eq("pos", 32'(pos), 32'(m_pos));
        check_eq("dir", 32'(dir), 32'(m_dir));
        check_eq("an", 32'(an), 32'(exp_an));
        check_eq("sseg", 32'(sseg), 32'(exp_sseg));
    endtask

    task automatic cycle(input logic r_n, input logic e, input logic c);
        reset_n = r_n;
        en      = e;
        cw      = c;
        @(posedge clk);
        model_edge(r_n, e, c);
        #1;
        check_all();
    endtask

    initial begin
        logic c_hold;
        n_vec   = 0;
        n_err   = 0;
        m_cnt   = 0;
        m_pos   = 0;
        m_dir   = 1;
        m_tick  = 0;
        reset_n = 1'b0;
        en      = 1'b0;
        cw      = 1'b1;
        @(negedge clk);

        // Reset state
        cycle(1'b0, 1'b1, 1'b0);
        cycle(1'b0, 1'b1, 1'b0);

        // Full clockwise revolution plus wrap
        repeat (40) cycle(1'b1, 1'b1, 1'b1);

        // Counter-clockwise from reset: first step lands on 7
        cycle(1'b0, 1'b1, 1'b0);
        repeat (40) cycle(1'b1, 1'b1, 1'b0);

        // cw pulsed between ticks has no effect
        cycle(1'b1, 1'b1, 1'b1);
        cycle(1'b1, 1'b1, 1'b0);
        repeat (4) cycle(1'b1, 1'b1, 1'b0);

        // Freeze for 10 cycles mid-count, then resume
        cycle(1'b1, 1'b1, 1'b1);
        cycle(1'b1, 1'b1, 1'b1);
        repeat (10) cycle(1'b1, 1'b0, 1'b1);
        repeat (8) cycle(1'b1, 1'b1, 1'b1);

        // Reset mid-step
        repeat (3) cycle(1'b1, 1'b1, 1'b1);
        cycle(1'b0, 1'b1, 1'b0);
        repeat (6) cycle(1'b1, 1'b1, 1'b0);

        // Randomized: mostly enabled, sticky direction with random flips, rare reset
        c_hold = 1'b1;
        repeat (600) begin
            if ($urandom_range(0, 3) == 0) c_hold = ~c_hold;
            cycle(($urandom_range(0, 63) != 0), ($urandom_range(0, 7) != 0), c_hold);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
